pll_divn_sequencer: RTL and testbench
=====================================

Name: pll_divn_sequencer

Overview:
- Requester-side controller for the PLL's `brake` / `divn` interface.
- Accepts a new feedback-divide target over a valid/ready handshake and fires a brake pulse into the PLL.
- Ramps `divn` toward the target in bounded steps, then waits for the PLL lock indication.
- Reports completion or timeout; sits between the clock-config register block and the PLL, all on `refclk`.

Parameters:
- DIVN_W, 16, width of divide values
- DIVN_RESET, 20, divn driven out of reset
- DIVN_MIN, 4, lower clamp for requested target
- DIVN_MAX, 1000, upper clamp for requested target
- DIV_STEP, 1, maximum divn change per ramp step
- BRAKE_PULSE_CYCLES, 4, refclk cycles brake is held high
- HOLD_CYCLES, 32, refclk cycles held at each intermediate divn
- LOCK_TIMEOUT, 1024, refclk cycles allowed for lock after final step

Ports:
- refclk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  new target offered
- req_ready  output  1  sequencer can accept a target
- req_divn  input  DIVN_W  requested divide value
- pll_locked  input  1  PLL phase-lock status, synchronous to refclk
- err_clr  input  1  clears the error state
- brake  output  1  brake request to the PLL
- divn  output  DIVN_W  divide value to the PLL, registered
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- timeout_err  output  1  sticky lock-timeout flag

Behaviour:
- Reset values: divn=DIVN_RESET, brake=0, done=0, timeout_err=0, busy=0, state=IDLE. Timers and target register are cleared.
- Reset asserted mid-sequence aborts immediately to reset values; no partial state is retained.
- req_ready = (state==IDLE), combinational from the state register.
- A transfer occurs when req_valid & req_ready are both high on a rising edge.
- On transfer, target = clamp(req_divn, DIVN_MIN, DIVN_MAX), registered.
- Transfer with target == divn: no brake is issued. done=1 on the next cycle and state stays IDLE.
- Transfer with target != divn: next state BRAKE.
- BRAKE:
  - brake=1 for exactly BRAKE_PULSE_CYCLES cycles, starting the cycle after the transfer.
  - divn is held during BRAKE.
  - Then go to STEP.
- STEP (one cycle):
  - divn <= divn ± min(DIV_STEP, |target−divn|), moving toward target.
  - Arithmetic is unsigned DIVN_W with the difference computed at DIVN_W+1 bits; divn never overshoots or wraps.
  - Then go to HOLD.
- HOLD:
  - Counts HOLD_CYCLES cycles.
  - At expiry: go to WAIT_LOCK if divn==target, else STEP.
  - pll_locked is ignored in BRAKE, STEP and HOLD.
- WAIT_LOCK:
  - Timer starts at 0 on entry.
  - pll_locked==1 sampled on any cycle: go to DONE.
  - Timer reaching LOCK_TIMEOUT−1 without lock: go to ERROR.
  - Lock arriving on the same edge as the timeout wins; that case goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERROR:
  - timeout_err=1, held; req_ready=0; divn holds at target.
  - err_clr=1: timeout_err cleared next cycle, return to IDLE.
- Requests while busy are not accepted; req_valid may stay high and is taken on return to IDLE.
- brake is driven from a flop: glitch-free, no combinational path from inputs.
- Ramp length = ceil(|Δ|/DIV_STEP) STEP+HOLD pairs.
- Total cycles from transfer to DONE entry = BRAKE_PULSE_CYCLES + steps·(1+HOLD_CYCLES) + lock wait.

Optional Feature:
- Macro: PLL_DIVN_SEQ_RETRY_EN
- Defined:
  - The first lock timeout of a request does not enter ERROR.
  - The sequencer re-enters BRAKE (full BRAKE_PULSE_CYCLES pulse, divn unchanged), then returns directly to WAIT_LOCK with a fresh timer.
  - A second timeout enters ERROR.
  - The retry flag clears on every new transfer and on reset.
- Undefined: the first timeout enters ERROR; no retry logic is present.

Test Plan:
- Reset release, no request -> divn=20, brake=0, req_ready=1, busy=0, done=0 indefinitely.
- req_divn=23 from divn=20 (defaults), pll_locked=1 held -> brake high cycles 1–4 after the transfer. Then divn=21, 22, 23, each held 33 cycles. done pulses once; total 4+3·33+1 cycles to DONE; brake stays low after the pulse.
- req_divn=2000 -> target clamped to 1000. req_divn=20 equal to current divn -> done next cycle, brake never asserts, busy stays 0.
- req_divn=18, pll_locked=0 throughout -> after the ramp, 1024 cycles in WAIT_LOCK then timeout_err=1 and req_ready=0. err_clr pulse -> timeout_err=0, req_ready=1 next cycle. With PLL_DIVN_SEQ_RETRY_EN defined, a second brake pulse precedes the error.
- pll_locked toggling during HOLD, then high on the final timeout cycle -> lock ignored during the ramp; DONE taken, not ERROR.
- reset asserted mid-HOLD with divn=22 -> divn=20, brake=0, busy=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pll_divn_sequencer.sv
// PLL feedback-divider sequencer: brake pulse, bounded divn ramp, lock wait.
// Optional lock-timeout retry enabled by defining PLL_DIVN_SEQ_RETRY_EN.
module pll_divn_sequencer #(
  parameter int DIVN_W             = 16,
  parameter int DIVN_RESET         = 20,
  parameter int DIVN_MIN           = 4,
  parameter int DIVN_MAX           = 1000,
  parameter int DIV_STEP           = 1,
  parameter int BRAKE_PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES        = 32,
  parameter int LOCK_TIMEOUT       = 1024
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIVN_W-1:0] req_divn,
  input  logic              pll_locked,
  input  logic              err_clr,
  output logic              brake,
  output logic [DIVN_W-1:0] divn,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int CNT_MAX_A =
    (BRAKE_PULSE_CYCLES > HOLD_CYCLES) ?
    BRAKE_PULSE_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX =
    (CNT_MAX_A > LOCK_TIMEOUT) ?
    CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BRK_LAST =
    CNT_W'(BRAKE_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  localparam logic [DIVN_W-1:0] RST_V =
    DIVN_W'(DIVN_RESET);
  localparam logic [DIVN_W-1:0] MIN_V =
    DIVN_W'(DIVN_MIN);
  localparam logic [DIVN_W-1:0] MAX_V =
    DIVN_W'(DIVN_MAX);
  localparam logic [DIVN_W:0] STEP_V =
    (DIVN_W+1)'(DIV_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRAKE,
    S_STEP,
    S_HOLD,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q;
  logic [DIVN_W-1:0] divn_q;
  logic [DIVN_W-1:0] target_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              brake_q;
  logic              done_q;
  logic              err_q;
`ifdef PLL_DIVN_SEQ_RETRY_EN
  logic              retry_q;
`endif

  logic [DIVN_W-1:0] tgt_d;
  logic [DIVN_W-1:0] divn_d;
  logic              up_d;
  logic [DIVN_W:0]   mag_d;
  logic [DIVN_W:0]   step_d;
  logic [DIVN_W:0]   sum_d;

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign brake       = brake_q;
  assign divn        = divn_q;
  assign done        = done_q;
  assign timeout_err = err_q;

  // Clamp the requested divide value into the legal range.
  always_comb begin
    tgt_d = req_divn;
    if (req_divn < MIN_V) begin
      tgt_d = MIN_V;
    end else if (req_divn > MAX_V) begin
      tgt_d = MAX_V;
    end
  end

  // Next ramp value: at most one step toward target, saturating.
  always_comb begin
    up_d   = (target_q > divn_q);
    mag_d  = '0;
    step_d = '0;
    sum_d  = '0;
    divn_d = divn_q;
    if (up_d) begin
      mag_d = {1'b0, target_q} - {1'b0, divn_q};
    end else begin
      mag_d = {1'b0, divn_q} - {1'b0, target_q};
    end
    step_d = (mag_d < STEP_V) ? mag_d : STEP_V;
    if (up_d) begin
      sum_d  = {1'b0, divn_q} + step_d;
      divn_d = sum_d[DIVN_W] ? '1 : sum_d[DIVN_W-1:0];
    end else begin
      sum_d  = {1'b0, divn_q} - step_d;
      divn_d = sum_d[DIVN_W] ? '0 : sum_d[DIVN_W-1:0];
    end
  end

  // Sequencer FSM with registered brake/divn/done/error outputs.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      divn_q   <= RST_V;
      target_q <= '0;
      cnt_q    <= '0;
      brake_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PLL_DIVN_SEQ_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            target_q <= tgt_d;
            cnt_q    <= '0;
`ifdef PLL_DIVN_SEQ_RETRY_EN
            retry_q  <= 1'b0;
`endif
            if (tgt_d == divn_q) begin
              done_q <= 1'b1;
            end else begin
              brake_q <= 1'b1;
              state_q <= S_BRAKE;
            end
          end
        end
        S_BRAKE: begin
          if (cnt_q == BRK_LAST) begin
            brake_q <= 1'b0;
            cnt_q   <= '0;
`ifdef PLL_DIVN_SEQ_RETRY_EN
            state_q <= retry_q ? S_WAIT : S_STEP;
`else
            state_q <= S_STEP;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_STEP: begin
          divn_q  <= divn_d;
          cnt_q   <= '0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= '0;
            if (divn_q == target_q) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_STEP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_WAIT: begin
          if (pll_locked) begin
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else if (cnt_q == LOCK_LAST) begin
            cnt_q <= '0;
`ifdef PLL_DIVN_SEQ_RETRY_EN
            if (!retry_q) begin
              retry_q <= 1'b1;
              brake_q <= 1'b1;
              state_q <= S_BRAKE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end
`else
            err_q   <= 1'b1;
            state_q <= S_ERROR;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_divn_sequencer.sv
// Scoreboard bench for pll_divn_sequencer: directed requests, monitor checks
// latency, final divn, brake-pulse length and busy for each done/error event.
module tb_pll_divn_sequencer;

`ifdef PLL_DIVN_SEQ_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  logic        refclk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_divn;
  logic        pll_locked;
  logic        err_clr;
  logic        brake;
  logic [15:0] divn;
  logic        busy;
  logic        done;
  logic        timeout_err;

  pll_divn_sequencer dut (
    .refclk      (refclk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_divn    (req_divn),
    .pll_locked  (pll_locked),
    .err_clr     (err_clr),
    .brake       (brake),
    .divn        (divn),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int kind;
    int lat;
    int dv;
    int nbrk;
    int bsy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_n  = 0;
  int   resp_n = 0;

  int   cyc    = 0;
  int   t0     = 0;
  int   nbrk   = 0;
  int   bseen  = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a === e) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic push(input int k, input int l, input int d,
                      input int b, input int s);
    exp_t e;
    e.kind = k;
    e.lat  = l;
    e.dv   = d;
    e.nbrk = b;
    e.bsy  = s;
    q.push_back(e);
    exp_n++;
  endtask

  task automatic got(input int k);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_output: got kind %0d expected none", k);
    end else begin
      e = q.pop_front();
      chk("resp_kind", k, e.kind);
      chk("resp_latency", cyc - t0, e.lat);
      chk("resp_divn", int'(divn), e.dv);
      chk("resp_brake_cycles", nbrk, e.nbrk);
      chk("resp_busy_seen", bseen, e.bsy);
    end
    resp_n++;
  endtask

  // Track transfer edges and cycle count.
  always @(posedge refclk) begin
    cyc++;
    if (!reset && req_valid && req_ready) begin
      t0    = cyc;
      nbrk  = 0;
      bseen = 0;
    end
  end

  // Monitor: sample outputs mid-cycle and score done/error events.
  always @(negedge refclk) begin
    if (!reset) begin
      if (brake) nbrk++;
      if (busy) bseen = 1;
      if (done) got(0);
      if (timeout_err && !err_prev) got(1);
    end
    err_prev = timeout_err;
  end

  task automatic issue(input int v);
    @(negedge refclk);
    req_valid = 1'b1;
    req_divn  = 16'(v);
    @(posedge refclk);
    @(negedge refclk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (resp_n < exp_n && n < budget) begin
      @(negedge refclk);
      n++;
    end
    if (resp_n < exp_n) begin
      checks++;
      $display("FAIL wait_resp: got no response after %0d cycles, expected %0d",
               budget, exp_n);
      if (q.size() > 0) q.delete(0);
      resp_n = exp_n;
    end
  endtask

  initial begin
    int bad;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_divn   = '0;
    pll_locked = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(negedge refclk);
    reset = 1'b0;

    bad = 0;
    repeat (10) begin
      @(negedge refclk);
      if (divn !== 16'd20 || brake !== 1'b0 || req_ready !== 1'b1 ||
          busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_divn", int'(divn), 20);
    chk("idle_brake", int'(brake), 0);
    chk("idle_ready", int'(req_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_stable_cycles_bad", bad, 0);

    push(0, 0, 20, 0, 0);
    issue(20);
    wait_resp(5);

    pll_locked = 1'b1;
    push(0, 4 + 3 * 33 + 1, 23, 4, 1);
    issue(23);
    repeat (4) @(negedge refclk);
    chk("ramp_divn_e4", int'(divn), 20);
    chk("ramp_brake_e4", int'(brake), 0);
    @(negedge refclk);
    chk("ramp_divn_e5", int'(divn), 21);
    repeat (32) @(negedge refclk);
    chk("ramp_divn_e37", int'(divn), 21);
    @(negedge refclk);
    chk("ramp_divn_e38", int'(divn), 22);
    repeat (32) @(negedge refclk);
    chk("ramp_divn_e70", int'(divn), 22);
    @(negedge refclk);
    chk("ramp_divn_e71", int'(divn), 23);
    wait_resp(100);

    pll_locked = 1'b0;
    push(0, 37 + 1024, 24, 4, 1);
    issue(24);
    for (int j = 1; j <= 37 + 1024; j++) begin
      if (j <= 37) pll_locked = j[0];
      else pll_locked = (j == 37 + 1024);
      @(negedge refclk);
    end
    pll_locked = 1'b0;
    wait_resp(5);

    @(negedge refclk);
    reset = 1'b1;
    @(negedge refclk);
    reset = 1'b0;
    issue(23);
    repeat (45) @(negedge refclk);
    chk("pre_reset_divn", int'(divn), 22);
    chk("pre_reset_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_divn", int'(divn), 20);
    chk("async_reset_brake", int'(brake), 0);
    chk("async_reset_busy", int'(busy), 0);
    @(negedge refclk);
    reset = 1'b0;

    push(1, 70 + 1024 + RETRY * (4 + 1024), 18, 4 + RETRY * 4, 1);
    issue(18);
    wait_resp(2500);
    @(negedge refclk);
    chk("err_flag", int'(timeout_err), 1);
    chk("err_ready", int'(req_ready), 0);
    repeat (5) @(negedge refclk);
    chk("err_held", int'(timeout_err), 1);
    chk("err_divn", int'(divn), 18);
    err_clr = 1'b1;
    @(negedge refclk);
    err_clr = 1'b0;
    chk("err_clr_flag", int'(timeout_err), 0);
    chk("err_clr_ready", int'(req_ready), 1);

    pll_locked = 1'b1;
    push(0, 4 + 14 * 33 + 1, 4, 4, 1);
    issue(0);
    wait_resp(600);

    push(0, 4 + 996 * 33 + 1, 1000, 4, 1);
    issue(2000);
    wait_resp(34000);

    repeat (3) @(negedge refclk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
